// File: rtl/risc_mem_responder.sv
// risc_mem_responder: instruction/data memories and byte-stream program loader for the RISC-V core.
// The loader fills imem little-endian and keeps the core in reset until a load completes.
module risc_mem_responder #(
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        pc_next,
  output logic [31:0]        if_inst,
  output logic [31:0]        if_pc,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic               mem_we,
  output logic [31:0]        DataB_out,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [7:0]         ld_byte,
  output logic               ld_ready,
  input  logic               ld_done,
  output logic [IMEM_AW:0]   ld_words,
  output logic               ld_err,
  output logic               core_rst_n
);
  typedef enum logic [1:0] {HOLD, LOAD, RUN} state_t;
  state_t state;
  logic [31:0] imem [1<<IMEM_AW];
  logic [31:0] dmem [1<<DMEM_AW];
  logic [1:0] idx, idx_next;
  logic [23:0] asm_q;
  logic run, take, word_done, full, unused_ok;
  assign run = state == RUN;
  assign ld_ready = state == LOAD;
  assign take = ld_ready && ld_valid && !ld_start;
  assign word_done = take && idx == 2'd3;
  // ld_words saturates at the depth, so its top bit alone flags a full memory
  assign full = ld_words[IMEM_AW];
  assign idx_next = take ? idx + 2'd1 : idx;
  assign DataB_out = dmem[mem_addr[DMEM_AW-1:0]];
  assign unused_ok = &{1'b0, mem_addr[31:DMEM_AW]};
  always_ff @(posedge clk) begin
    if (word_done && !full) imem[ld_words[IMEM_AW-1:0]] <= {ld_byte, asm_q};
    if (run && mem_we) dmem[mem_addr[DMEM_AW-1:0]] <= mem_wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLD;
      core_rst_n <= 1'b0;
      if_inst <= NOP_INST;
      if_pc <= '0;
      ld_words <= '0;
      ld_err <= 1'b0;
      idx <= '0;
      asm_q <= '0;
    end else begin
      core_rst_n <= run;
      if_inst <= run ? imem[pc_next[IMEM_AW-1:0]] : NOP_INST;
      if_pc <= run ? pc_next : '0;
      if (ld_start) begin
        state <= LOAD;
        idx <= '0;
        ld_words <= '0;
        ld_err <= 1'b0;
        asm_q <= '0;
      end else if (ld_ready) begin
        if (take) begin
          idx <= idx_next;
          asm_q <= {ld_byte, asm_q[23:8]};
        end
        if (word_done && full) ld_err <= 1'b1;
        if (word_done && !full) ld_words <= ld_words + 1'b1;
        if (ld_done) begin
          state <= RUN;
          idx <= '0;
          if (idx_next != 2'd0) ld_err <= 1'b1;
        end
      end
    end
  end
endmodule
